// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: queue entry layout,
// fetch FSM encoding, default widths and a counter-width helper.
// No logic, no latency, no backpressure; imported by if_queue and if_fetch_queue.
package if_pkg;

  localparam int PC_W_DEF   = 30;
  localparam int INSN_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  // Entry layout at the default widths; the top rebuilds the same shape
  // at its own parameterised widths.
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INSN_W_DEF-1:0] insn;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO holding fetched {pc, insn} entries, generic in entry type.
// Latency: a push is visible at head_dat the cycle after; pop advances on the clock edge.
// Backpressure: none internally; callers must not push when full (credit-managed upstream).
// Ports: cpu_clk/cpu_rstn, clear (drops all entries), push/push_dat, pop,
//        head_dat (oldest entry), occupancy, full, empty.
module if_queue #(
  parameter type entry_t = logic [61:0],
  parameter int  DEPTH   = 4
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 push_dat,
  input  logic                   pop,
  output entry_t                 head_dat,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign occupancy = count_q;
  assign head_dat  = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: in-order imem requests, DEPTH-entry {pc, insn} queue, one insn/cycle to decode.
// Latency: gnt -> rvalid (memory) -> queue push -> output register; if_en rises 2 cycles after the rvalid cycle starts.
// Backpressure: stall holds the output; requests stop once queue occupancy + outstanding reaches DEPTH.
// Ports: cpu_clk, cpu_rstn (async, active-low); imem_req/imem_addr/imem_gnt request side;
//        imem_rvalid/imem_rdata in-order responses; stall, flush/new_pc, br_taken/br_addr from the
//        pipeline; if_pc/if_insn/if_en towards decode.
// Optional: define IF_FETCH_PERF_EN to add perf_bubble_cnt and perf_redirect_cnt (saturating) outputs.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSN_W   = INSN_W_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   new_pc,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_addr,
  output logic [PC_W-1:0]   if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic              if_en
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } q_entry_t;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fpc_q, fpc_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;

  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              req_grant;
  logic              rsp_ok;
  logic              rsp_drop;
  logic              credit_ok;
  logic              advance;
  logic [CNT_W:0]    inflight;

  logic              q_push, q_pop, q_full, q_empty;
  q_entry_t          q_push_dat, q_head;
  logic [CNT_W-1:0]  q_occupancy;

  // flush wins over br_taken; neither is gated by stall.
  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? new_pc : br_addr;

  assign req_grant = imem_req & imem_gnt;
  // A response with nothing outstanding is spurious and ignored.
  assign rsp_ok    = imem_rvalid & (outstanding_q != '0);

  // Every request in flight already owns a queue slot, so a response can always be pushed.
  assign inflight  = (CNT_W+1)'(q_occupancy) + (CNT_W+1)'(outstanding_q);
  assign credit_ok = (inflight < (CNT_W+1)'(DEPTH));

  // The output register takes a new head when empty or when decode accepts the current one.
  assign advance = !if_en_q || !stall;

  assign q_push     = rsp_ok && !rsp_drop && !redirect;
  assign q_pop      = advance && !q_empty && !redirect;
  assign q_push_dat = '{pc: rpc_q, insn: imem_rdata};

  if_queue #(
    .entry_t (q_entry_t),
    .DEPTH   (DEPTH)
  ) u_queue (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .clear     (redirect),
    .push      (q_push),
    .push_dat  (q_push_dat),
    .pop       (q_pop),
    .head_dat  (q_head),
    .occupancy (q_occupancy),
    .full      (q_full),
    .empty     (q_empty)
  );

  // FSM state register
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN exactly while wrong-path responses remain to be dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:       state_d = RUN;
      RUN, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
      default:    state_d = BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req = 1'b0;
    rsp_drop = 1'b0;
    case (state_q)
      RUN: begin
        imem_req = credit_ok;
      end
      DRAIN: begin
        imem_req = credit_ok;
        rsp_drop = rsp_ok;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if_pc_d       = if_pc_q;
    if_insn_d     = if_insn_q;
    if_en_d       = if_en_q;

    case ({req_grant, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (req_grant) begin
      fpc_d = fpc_q + PC_W'(1);
    end
    if (q_push) begin
      rpc_d = rpc_q + PC_W'(1);
    end
    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end

    if (advance) begin
      if (!q_empty) begin
        if_pc_d   = q_head.pc;
        if_insn_d = q_head.insn;
        if_en_d   = 1'b1;
      end else begin
        if_en_d   = 1'b0;
      end
    end

    // Every request still in flight after this edge belongs to the old path.
    // outstanding_d already excludes this cycle's response and includes this
    // cycle's grant, and it replaces (not adds to) any drop count left over.
    if (redirect) begin
      fpc_d      = redirect_pc;
      rpc_d      = redirect_pc;
      drop_cnt_d = outstanding_d;
      if_pc_d    = redirect_pc;
      if_insn_d  = '0;
      if_en_d    = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      fpc_q         <= RESET_PC;
      rpc_q         <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      if_pc_q       <= '0;
      if_insn_q     <= '0;
      if_en_q       <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if_pc_q       <= if_pc_d;
      if_insn_q     <= if_insn_d;
      if_en_q       <= if_en_d;
    end
  end

  assign imem_addr = fpc_q;
  assign if_pc     = if_pc_q;
  assign if_insn   = if_insn_q;
  assign if_en     = if_en_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_bubble_q, perf_bubble_d;
  logic [31:0] perf_redirect_q, perf_redirect_d;

  always_comb begin
    perf_bubble_d   = perf_bubble_q;
    perf_redirect_d = perf_redirect_q;
    if (!stall && !if_en_q && (state_q != BOOT) && (perf_bubble_q != '1)) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
    if (redirect && (perf_redirect_q != '1)) begin
      perf_redirect_d = perf_redirect_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      perf_bubble_q   <= '0;
      perf_redirect_q <= '0;
    end else begin
      perf_bubble_q   <= perf_bubble_d;
      perf_redirect_q <= perf_redirect_d;
    end
  end

  assign perf_bubble_cnt   = perf_bubble_q;
  assign perf_redirect_cnt = perf_redirect_q;
`endif

  // A response with no request in flight indicates a memory-side protocol error.
  a_no_spurious_rsp: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    !(imem_rvalid && (outstanding_q == '0)));

  // The credit rule must make a push into a full queue impossible.
  a_push_has_room: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    !(q_push && q_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int PC_W   = 30;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;

  logic              cpu_clk = 1'b0;
  logic              cpu_rstn = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [INSN_W-1:0] imem_rdata = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [PC_W-1:0]   new_pc = '0;
  logic              br_taken = 1'b0;
  logic [PC_W-1:0]   br_addr = '0;
  logic [PC_W-1:0]   if_pc;
  logic [INSN_W-1:0] if_insn;
  logic              if_en;

  always #5 cpu_clk = ~cpu_clk;

  if_fetch_queue #(
    .PC_W     (PC_W),
    .INSN_W   (INSN_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory model: in-order response queue with per-request due cycle.
  logic [PC_W-1:0] pend_addr[$];
  int              pend_due[$];
  int              mem_lat = 1;
  int              gnt_pct = 100;

  // Reference model: expected next consumed PC and expected next fetch address.
  logic [PC_W-1:0]   exp_pc = '0;
  logic [PC_W-1:0]   fetch_exp = '0;
  logic              prev_redir = 1'b0;
  logic              prev_hold = 1'b0;
  logic [PC_W-1:0]   prev_tgt = '0;
  logic [PC_W-1:0]   prev_pc = '0;
  logic [INSN_W-1:0] prev_insn = '0;
  int                consumed = 0;

  typedef struct {
    logic            stall;
    logic            req;
    logic [PC_W-1:0] addr;
    logic            en;
    logic [PC_W-1:0] pc;
  } vec_t;
  vec_t vecs[24];

  function automatic logic [INSN_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {a, 2'b01} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic s, input logic rq, input int a, input logic e, input int p);
    vecs[i].stall = s;
    vecs[i].req   = rq;
    vecs[i].addr  = PC_W'(a);
    vecs[i].en    = e;
    vecs[i].pc    = PC_W'(p);
  endtask

  // Called at a negedge: check current outputs against the model, drive this
  // cycle's inputs, advance the memory/reference models, wait one cycle.
  task automatic step(input logic s, input logic f, input logic [PC_W-1:0] np,
                      input logic b, input logic [PC_W-1:0] ba);
    logic            g;
    logic            redir;
    logic [PC_W-1:0] tgt;
    if (prev_redir) begin
      check("redir_en", 64'(if_en), 64'd0);
      check("redir_pc", 64'(if_pc), 64'(prev_tgt));
      check("redir_insn", 64'(if_insn), 64'd0);
    end else if (prev_hold) begin
      check("hold_en", 64'(if_en), 64'd1);
      check("hold_pc", 64'(if_pc), 64'(prev_pc));
      check("hold_insn", 64'(if_insn), 64'(prev_insn));
    end
    if (if_en && !s) begin
      check("seq_pc", 64'(if_pc), 64'(exp_pc));
      check("seq_insn", 64'(if_insn), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 1'b1;
      consumed++;
    end
    g = ($urandom_range(99) < gnt_pct);
    if (imem_req && g) begin
      check("req_addr", 64'(imem_addr), 64'(fetch_exp));
      check("credit", 64'(pend_addr.size() < DEPTH), 64'd1);
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + mem_lat);
      fetch_exp = fetch_exp + 1'b1;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    redir    = f | b;
    tgt      = f ? np : ba;
    imem_gnt = g;
    stall    = s;
    flush    = f;
    new_pc   = np;
    br_taken = b;
    br_addr  = ba;
    prev_redir = redir;
    prev_tgt   = tgt;
    prev_hold  = if_en && s && !redir;
    prev_pc    = if_pc;
    prev_insn  = if_insn;
    if (redir) begin
      exp_pc    = tgt;
      fetch_exp = tgt;
    end
    @(negedge cpu_clk);
    cyc++;
  endtask

  task automatic wait_valid(input string name, input logic [PC_W-1:0] pc);
    int n;
    n = 0;
    while (!if_en && n < 50) begin
      step(1'b0, 1'b0, '0, 1'b0, '0);
      n++;
    end
    check({name, "_valid"}, 64'(if_en), 64'd1);
    check({name, "_pc"}, 64'(if_pc), 64'(pc));
    check({name, "_insn"}, 64'(if_insn), 64'(mem_word(pc)));
  endtask

  task automatic do_reset();
    cpu_rstn    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    br_taken    = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_pc     = '0;
    fetch_exp  = '0;
    prev_redir = 1'b0;
    prev_hold  = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  initial begin
    int start;
    int n;

    // cycle-by-cycle expectations: gnt always, 1-cycle response latency
    set_vec(0,  0, 0, 0, 0, 0);
    set_vec(1,  0, 1, 0, 0, 0);
    set_vec(2,  0, 1, 1, 0, 0);
    set_vec(3,  0, 1, 2, 0, 0);
    set_vec(4,  0, 1, 3, 1, 0);
    set_vec(5,  0, 1, 4, 1, 1);
    set_vec(6,  0, 1, 5, 1, 2);
    set_vec(7,  0, 1, 6, 1, 3);
    set_vec(8,  1, 1, 7, 1, 4);
    set_vec(9,  1, 1, 8, 1, 4);
    for (int i = 10; i < 18; i++) set_vec(i, 1, 0, 9, 1, 4);
    set_vec(18, 0, 0, 9, 1, 4);
    set_vec(19, 0, 1, 9, 1, 5);
    set_vec(20, 0, 1, 10, 1, 6);
    set_vec(21, 0, 1, 11, 1, 7);
    set_vec(22, 0, 1, 12, 1, 8);
    set_vec(23, 0, 1, 13, 1, 9);

    do_reset();
    check("rst_insn", 64'(if_insn), 64'd0);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("vec%0d_req", i), 64'(imem_req), 64'(vecs[i].req));
      check($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vecs[i].addr));
      check($sformatf("vec%0d_en", i), 64'(if_en), 64'(vecs[i].en));
      check($sformatf("vec%0d_pc", i), 64'(if_pc), 64'(vecs[i].pc));
      if (vecs[i].en) check($sformatf("vec%0d_insn", i), 64'(if_insn), 64'(mem_word(vecs[i].pc)));
      step(vecs[i].stall, 1'b0, '0, 1'b0, '0);
    end

    // branch with three requests in flight
    mem_lat = 4;
    n = 0;
    while (pend_addr.size() < 3 && n < 20) begin
      step(1'b0, 1'b0, '0, 1'b0, '0);
      n++;
    end
    check("br_inflight", 64'(pend_addr.size() >= 3), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, PC_W'(32'h100));
    wait_valid("br", PC_W'(32'h100));

    // flush and branch together: flush target wins
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, PC_W'(32'h200), 1'b1, PC_W'(32'h300));
    wait_valid("flush_pri", PC_W'(32'h200));

    // second redirect while still draining the first
    repeat (4) step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, PC_W'(32'h80), 1'b0, '0);
    check("drain_pending", 64'(pend_addr.size() >= 2), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, PC_W'(32'h40));
    wait_valid("drain", PC_W'(32'h40));
    repeat (6) step(1'b0, 1'b0, '0, 1'b0, '0);

    // PC wrap at 2^PC_W
    mem_lat = 1;
    step(1'b0, 1'b1, PC_W'(32'h3FFF_FFFF), 1'b0, '0);
    wait_valid("wrap_hi", PC_W'(32'h3FFF_FFFF));
    step(1'b0, 1'b0, '0, 1'b0, '0);
    wait_valid("wrap_lo", '0);

    // asynchronous reset in the middle of a burst
    repeat (5) step(1'b0, 1'b0, '0, 1'b0, '0);
    cpu_rstn = 1'b0;
    #1;
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_addr", 64'(imem_addr), 64'd0);
    check("arst_en", 64'(if_en), 64'd0);
    check("arst_pc", 64'(if_pc), 64'd0);
    check("arst_insn", 64'(if_insn), 64'd0);
    @(negedge cpu_clk);
    do_reset();
    wait_valid("post_rst", '0);

    // randomized traffic against the sequence model
    gnt_pct = 70;
    start = consumed;
    for (int i = 0; i < 3000; i++) begin
      logic            s, f, b;
      logic [PC_W-1:0] t1, t2;
      mem_lat = $urandom_range(4, 1);
      s  = ($urandom_range(99) < 30);
      f  = ($urandom_range(99) < 2);
      b  = ($urandom_range(99) < 3);
      t1 = PC_W'($urandom);
      t2 = PC_W'($urandom);
      step(s, f, t1, b, t2);
    end
    check("progress", 64'((consumed - start) > 300), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
